// File: rtl/ace_snoop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ace_snoop_ctrl
// Description : ACE snoop sequencer for one L1 data cache. Accepts one AC
//               snoop at a time, looks the line up, applies any required
//               state update, returns the CR response and streams the line
//               over CD when data transfer is required.
// Revision    : 1.0 - initial release
// ============================================================================
module ace_snoop_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // AC channel
    input  logic              ac_valid_i,
    input  logic [ADDR_W-1:0] ac_addr_i,
    input  logic [3:0]        ac_snoop_i,
    output logic              ac_ready_o,
    // CR channel
    output logic              cr_valid_o,
    output logic [4:0]        cr_resp_o,
    input  logic              cr_ready_i,
    // CD channel
    output logic              cd_valid_o,
    output logic [DATA_W-1:0] cd_data_o,
    output logic              cd_last_o,
    input  logic              cd_ready_i,
    // Cache lookup
    output logic              lookup_req_o,
    output logic [ADDR_W-1:0] lookup_addr_o,
    input  logic              lookup_gnt_i,
    input  logic              lookup_valid_i,
    input  logic              lookup_hit_i,
    input  logic              lookup_dirty_i,
    input  logic              lookup_shared_i,
    input  logic [LINE_W-1:0] lookup_data_i,
    // Cache state update
    output logic              upd_valid_o,
    output logic [1:0]        upd_op_o,
    input  logic              upd_ready_i,
    output logic              busy_o
);

    localparam int NB_BEATS = LINE_W / DATA_W;
    localparam int CNT_W    = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
    localparam int OFF_W    = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(NB_BEATS - 1);

    // Snoop encodings handled by this controller
    localparam logic [3:0] C_READ_ONCE     = 4'b0000;
    localparam logic [3:0] C_READ_SHARED   = 4'b0001;
    localparam logic [3:0] C_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] C_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] C_MAKE_INVALID  = 4'b1101;
    localparam logic [3:0] C_CLEAN_SHARED  = 4'b1000;

    // Update operations
    localparam logic [1:0] C_OP_NONE  = 2'b00;
    localparam logic [1:0] C_OP_INVAL = 2'b01;
    localparam logic [1:0] C_OP_MKSHR = 2'b10;
    localparam logic [1:0] C_OP_CLEAN = 2'b11;

    // FSM states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_WAIT_RSP = 3'd2;
    localparam logic [2:0] S_UPDATE   = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;
    localparam logic [2:0] S_DATA     = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_snoop;
    logic [LINE_W-1:0] r_line;
    logic [4:0]        r_resp;
    logic [1:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;

    logic [4:0]        w_resp;
    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_addr_aligned;
    logic              w_unused_addr_bits;
    logic [DATA_W-1:0] w_beats [NB_BEATS];

    // Offset bits within the line are dropped; the lookup is line-granular
    assign w_addr_aligned     = {ac_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_unused_addr_bits = ^ac_addr_i[OFF_W-1:0];

    // Split the latched line into CD beats, lowest beat first
    for (genvar gi = 0; gi < NB_BEATS; gi++) begin : g_beat
        assign w_beats[gi] = r_line[gi*DATA_W +: DATA_W];
    end

    // Response {WasUnique, IsShared, PassDirty, Error, DataTransfer} and update op
    always_comb begin
        w_resp = 5'b00000;
        w_op   = C_OP_NONE;
        if (lookup_hit_i) begin
            case (r_snoop)
                C_READ_ONCE: begin
                    w_resp = {~lookup_shared_i, 1'b1, 1'b0, 1'b0, 1'b1};
                end
                C_READ_SHARED: begin
                    w_resp = {~lookup_shared_i, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
                    w_op   = C_OP_MKSHR;
                end
                C_READ_UNIQUE: begin
                    w_resp = {~lookup_shared_i, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
                    w_op   = C_OP_INVAL;
                end
                C_CLEAN_INVALID: begin
                    w_resp = {~lookup_shared_i, 1'b0, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    w_op   = C_OP_INVAL;
                end
                C_MAKE_INVALID: begin
                    w_resp = {~lookup_shared_i, 1'b0, 1'b0, 1'b0, 1'b0};
                    w_op   = C_OP_INVAL;
                end
                C_CLEAN_SHARED: begin
                    w_resp = {~lookup_shared_i, 1'b1, lookup_dirty_i, 1'b0, lookup_dirty_i};
                    w_op   = C_OP_CLEAN;
                end
                default: begin
                    w_resp = 5'b00000;
                    w_op   = C_OP_NONE;
                end
            endcase
        end
    end

    // Snoop sequencing FSM with latched request, lookup result and beat counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_snoop <= '0;
            r_line  <= '0;
            r_resp  <= '0;
            r_op    <= C_OP_NONE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ac_valid_i) begin
                        r_addr  <= w_addr_aligned;
                        r_snoop <= ac_snoop_i;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_gnt_i) begin
                        r_state <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (lookup_valid_i) begin
                        r_line  <= lookup_data_i;
                        r_resp  <= w_resp;
                        r_op    <= w_op;
                        r_state <= (w_op != C_OP_NONE) ? S_UPDATE : S_RESP;
                    end
                end
                S_UPDATE: begin
                    if (upd_ready_i) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (cr_ready_i) begin
                        r_cnt   <= '0;
                        r_state <= r_resp[0] ? S_DATA : S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cd_ready_i) begin
                        if (r_cnt == C_LAST_BEAT) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so payloads stay stable under stall
    assign ac_ready_o    = (r_state == S_IDLE) && !rst_i;
    assign busy_o        = (r_state != S_IDLE);
    assign lookup_req_o  = (r_state == S_LOOKUP);
    assign lookup_addr_o = r_addr;
    assign upd_valid_o   = (r_state == S_UPDATE);
    assign upd_op_o      = r_op;
    assign cr_valid_o    = (r_state == S_RESP);
    assign cr_resp_o     = r_resp;
    assign cd_valid_o    = (r_state == S_DATA);
    assign cd_data_o     = w_beats[r_cnt];
    assign cd_last_o     = (r_state == S_DATA) && (r_cnt == C_LAST_BEAT);

endmodule
`default_nettype wire

// File: tb/tb_ace_snoop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ace_snoop_ctrl
// Description : Directed scoreboard bench for ace_snoop_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ace_snoop_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         ac_valid_i;
    logic [63:0]  ac_addr_i;
    logic [3:0]   ac_snoop_i;
    logic         ac_ready_o;
    logic         cr_valid_o;
    logic [4:0]   cr_resp_o;
    logic         cr_ready_i;
    logic         cd_valid_o;
    logic [63:0]  cd_data_o;
    logic         cd_last_o;
    logic         cd_ready_i;
    logic         lookup_req_o;
    logic [63:0]  lookup_addr_o;
    logic         lookup_gnt_i;
    logic         lookup_valid_i;
    logic         lookup_hit_i;
    logic         lookup_dirty_i;
    logic         lookup_shared_i;
    logic [127:0] lookup_data_i;
    logic         upd_valid_o;
    logic [1:0]   upd_op_o;
    logic         upd_ready_i;
    logic         busy_o;

    ace_snoop_ctrl #(
        .ADDR_W(64),
        .DATA_W(64),
        .LINE_W(128)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ac_valid_i     (ac_valid_i),
        .ac_addr_i      (ac_addr_i),
        .ac_snoop_i     (ac_snoop_i),
        .ac_ready_o     (ac_ready_o),
        .cr_valid_o     (cr_valid_o),
        .cr_resp_o      (cr_resp_o),
        .cr_ready_i     (cr_ready_i),
        .cd_valid_o     (cd_valid_o),
        .cd_data_o      (cd_data_o),
        .cd_last_o      (cd_last_o),
        .cd_ready_i     (cd_ready_i),
        .lookup_req_o   (lookup_req_o),
        .lookup_addr_o  (lookup_addr_o),
        .lookup_gnt_i   (lookup_gnt_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_hit_i   (lookup_hit_i),
        .lookup_dirty_i (lookup_dirty_i),
        .lookup_shared_i(lookup_shared_i),
        .lookup_data_i  (lookup_data_i),
        .upd_valid_o    (upd_valid_o),
        .upd_op_o       (upd_op_o),
        .upd_ready_i    (upd_ready_i),
        .busy_o         (busy_o)
    );

    // Scoreboard queues: expected update ops, CR responses and CD beats {last, data}
    logic [1:0]  q_op   [$];
    logic [4:0]  q_cr   [$];
    logic [64:0] q_beat [$];

    int checks = 0;
    int errors = 0;

    logic [127:0] c_line_a = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    logic [127:0] c_line_b = {64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF};
    logic [127:0] c_line_c = {64'hA5A5_5A5A_C3C3_3C3C, 64'h0F0F_F0F0_1234_8765};

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one snoop, plays the cache, and scores every DUT output against the queues
    task automatic run_snoop(
        input string        nm,
        input logic [3:0]   snp,
        input logic [63:0]  addr,
        input logic         hit,
        input logic         dirty,
        input logic         shared,
        input logic [127:0] line,
        input int           gnt_wait,
        input int           cr_wait,
        input bit           cd_toggle,
        input int           abort_beats,
        input bit           exp_upd,
        input logic [1:0]   exp_op,
        input logic [4:0]   exp_cr
    );
        int gcnt      = 0;
        int crs       = cr_wait;
        int nbeats    = 0;
        bit granted   = 1'b0;
        bit delivered = 1'b0;
        bit done      = 1'b0;
        bit aborted   = 1'b0;
        bit phase     = 1'b0;

        q_cr.push_back(exp_cr);
        if (exp_upd) q_op.push_back(exp_op);
        if (exp_cr[0]) begin
            for (int k = 0; k < 2; k++) q_beat.push_back({(k == 1), line[k*64 +: 64]});
        end

        @(negedge clk_i);
        chk({nm, "_ac_ready"}, ac_ready_o, 1);
        ac_valid_i = 1'b1;
        ac_addr_i  = addr;
        ac_snoop_i = snp;
        @(posedge clk_i);
        #1;
        ac_valid_i = 1'b0;

        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk_i);
            lookup_gnt_i = 1'b0;
            upd_ready_i  = 1'b0;
            cr_ready_i   = 1'b0;
            cd_ready_i   = 1'b0;
            if (abort_beats >= 0 && nbeats == abort_beats && cd_valid_o) begin
                rst_i = 1'b1;
                @(posedge clk_i);
                #1;
                chk({nm, "_rst_cd_valid"}, cd_valid_o, 0);
                chk({nm, "_rst_cr_valid"}, cr_valid_o, 0);
                chk({nm, "_rst_upd_valid"}, upd_valid_o, 0);
                chk({nm, "_rst_lookup_req"}, lookup_req_o, 0);
                chk({nm, "_rst_busy"}, busy_o, 0);
                chk({nm, "_rst_cd_last"}, cd_last_o, 0);
                rst_i = 1'b0;
                #1;
                chk({nm, "_rst_ac_ready"}, ac_ready_o, 1);
                q_op.delete();
                q_cr.delete();
                q_beat.delete();
                aborted = 1'b1;
                done    = 1'b1;
            end else begin
                if (granted && !delivered) begin
                    lookup_valid_i  = 1'b1;
                    lookup_hit_i    = hit;
                    lookup_dirty_i  = dirty;
                    lookup_shared_i = shared;
                    lookup_data_i   = line;
                    delivered       = 1'b1;
                end else begin
                    lookup_valid_i = 1'b0;
                end
                chk({nm, "_cr_cd_excl"}, cr_valid_o & cd_valid_o, 0);
                if (lookup_req_o) begin
                    chk({nm, "_lookup_addr"}, lookup_addr_o, addr & ~64'hF);
                    chk({nm, "_busy"}, busy_o, 1);
                    if (gcnt < gnt_wait) begin
                        gcnt++;
                    end else begin
                        lookup_gnt_i = 1'b1;
                        granted      = 1'b1;
                    end
                end
                if (upd_valid_o) begin
                    if (q_op.size() == 0) begin
                        chk({nm, "_upd_unexpected"}, upd_valid_o, 0);
                    end else begin
                        chk({nm, "_upd_op"}, upd_op_o, q_op[0]);
                        upd_ready_i = 1'b1;
                        void'(q_op.pop_front());
                    end
                end
                if (cr_valid_o) begin
                    if (q_cr.size() == 0) begin
                        chk({nm, "_cr_unexpected"}, cr_valid_o, 0);
                    end else begin
                        chk({nm, "_cr_resp"}, cr_resp_o, q_cr[0]);
                        chk({nm, "_cr_no_pending_upd"}, q_op.size(), 0);
                        if (crs > 0) begin
                            crs--;
                        end else begin
                            cr_ready_i = 1'b1;
                            void'(q_cr.pop_front());
                        end
                    end
                end
                if (cd_valid_o) begin
                    if (q_beat.size() == 0) begin
                        chk({nm, "_cd_unexpected"}, cd_valid_o, 0);
                    end else begin
                        chk({nm, "_cd_data"}, cd_data_o, q_beat[0][63:0]);
                        chk({nm, "_cd_last"}, cd_last_o, q_beat[0][64]);
                        if (!cd_toggle || phase) begin
                            cd_ready_i = 1'b1;
                            void'(q_beat.pop_front());
                            nbeats++;
                        end
                        phase = !phase;
                    end
                end
                if (delivered && ac_ready_o && lookup_valid_i == 1'b0) begin
                    chk({nm, "_idle_busy"}, busy_o, 0);
                    done = 1'b1;
                end
            end
        end
        lookup_gnt_i   = 1'b0;
        lookup_valid_i = 1'b0;
        upd_ready_i    = 1'b0;
        cr_ready_i     = 1'b0;
        cd_ready_i     = 1'b0;
        chk({nm, "_completed"}, done, 1);
        if (!aborted) begin
            chk({nm, "_queues_empty"}, q_op.size() + q_cr.size() + q_beat.size(), 0);
            chk({nm, "_cd_beats"}, nbeats, exp_cr[0] ? 2 : 0);
        end
        q_op.delete();
        q_cr.delete();
        q_beat.delete();
    endtask

    initial begin
        rst_i           = 1'b1;
        ac_valid_i      = 1'b0;
        ac_addr_i       = '0;
        ac_snoop_i      = '0;
        cr_ready_i      = 1'b0;
        cd_ready_i      = 1'b0;
        lookup_gnt_i    = 1'b0;
        lookup_valid_i  = 1'b0;
        lookup_hit_i    = 1'b0;
        lookup_dirty_i  = 1'b0;
        lookup_shared_i = 1'b0;
        lookup_data_i   = '0;
        upd_ready_i     = 1'b0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ac_ready", ac_ready_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_cr_valid", cr_valid_o, 0);
        chk("reset_cr_resp", cr_resp_o, 0);
        chk("reset_cd_valid", cd_valid_o, 0);
        chk("reset_cd_last", cd_last_o, 0);
        chk("reset_lookup_req", lookup_req_o, 0);
        chk("reset_upd_valid", upd_valid_o, 0);
        rst_i = 1'b0;

        // ReadShared, hit dirty unique: MAKE_SHARED then CR WU|IS|PD|DT
        run_snoop("rd_shared", 4'b0001, 64'h0000_0000_1000_0037, 1, 1, 0, c_line_a,
                  0, 0, 0, -1, 1, 2'b10, 5'b11101);
        // ReadUnique, miss: no update, empty CR, no data
        run_snoop("rd_unique_miss", 4'b0111, 64'h0000_0000_2000_0040, 0, 0, 0, c_line_b,
                  0, 0, 0, -1, 0, 2'b00, 5'b00000);
        // CleanInvalid, hit clean shared: invalidate, no data
        run_snoop("clean_inval", 4'b1001, 64'h0000_0000_3000_008F, 1, 0, 1, c_line_b,
                  0, 0, 0, -1, 1, 2'b01, 5'b00000);
        // MakeInvalid, hit unique: invalidate, WasUnique only
        run_snoop("make_inval", 4'b1101, 64'h0000_0000_4000_0010, 1, 1, 0, c_line_c,
                  0, 0, 0, -1, 1, 2'b01, 5'b10000);
        // ReadUnique with backpressure on grant, CR and CD
        run_snoop("backpressure", 4'b0111, 64'hFFFF_0000_5000_00F3, 1, 1, 1, c_line_c,
                  3, 4, 1, -1, 1, 2'b01, 5'b00101);
        // ReadOnce aborted by reset after the first CD beat
        run_snoop("rd_once_abort", 4'b0000, 64'h0000_0000_6000_0000, 1, 0, 0, c_line_b,
                  0, 0, 0, 1, 0, 2'b00, 5'b11001);
        // ReadOnce after reset completes fully
        run_snoop("rd_once", 4'b0000, 64'h0000_0000_6000_0008, 1, 0, 0, c_line_a,
                  0, 0, 0, -1, 0, 2'b00, 5'b11001);
        // Unsupported snoop encoding on a hit: nothing happens
        run_snoop("unsupported", 4'b1111, 64'h0000_0000_7000_0020, 1, 1, 0, c_line_c,
                  0, 0, 0, -1, 0, 2'b00, 5'b00000);
        // CleanShared, hit dirty unique: CLEAN then data
        run_snoop("clean_shared", 4'b1000, 64'h0000_0000_8000_0050, 1, 1, 0, c_line_c,
                  1, 1, 0, -1, 1, 2'b11, 5'b11101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
